// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the pipelined AXI4-Stream FIR.
// fir_resize performs the final saturate-or-wrap to the output width.
package fir_pkg;

    localparam int MAX_TAPS   = 64;
    localparam int FIR_WIDE_W = 128;

    function automatic int fir_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Guard bits cover the worst-case growth of summing NUM_TAPS full-scale products.
    function automatic int fir_acc_w(input int din_w, input int coef_w, input int taps);
        return din_w + coef_w + fir_clog2(taps);
    endfunction

    function automatic logic signed [FIR_WIDE_W-1:0] fir_resize(
        input logic signed [FIR_WIDE_W-1:0] v,
        input int                           out_w,
        input logic                         sat
    );
        logic signed [FIR_WIDE_W-1:0] hi;
        logic signed [FIR_WIDE_W-1:0] lo;
        logic signed [FIR_WIDE_W-1:0] r;
        hi = (FIR_WIDE_W'(1) << (out_w - 1)) - FIR_WIDE_W'(1);
        lo = ~hi;
        r  = v;
        if (sat) begin
            if (v > hi) begin
                r = hi;
            end else if (v < lo) begin
                r = lo;
            end
        end else begin
            for (int i = 0; i < FIR_WIDE_W; i++) begin
                r[i] = (i < out_w) ? v[i] : v[out_w - 1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_quantize.sv
// Output quantiser: floor shift of the accumulator by OUT_SHIFT, then resize to DATA_OUT_W.
// Out-of-range values clamp when FIR_SATURATE_EN is defined and wrap otherwise.
module fir_out_quantize
    import fir_pkg::*;
#(
    parameter int ACC_W      = 35,
    parameter int DATA_OUT_W = 32,
    parameter int OUT_SHIFT  = 0
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    output logic signed [DATA_OUT_W-1:0] data_o
);

`ifdef FIR_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [ACC_W-1:0]      shifted;
    logic signed [FIR_WIDE_W-1:0] wide;

    assign shifted = acc_i >>> OUT_SHIFT;
    assign wide    = {{(FIR_WIDE_W - ACC_W){shifted[ACC_W-1]}}, shifted};
    assign data_o  = DATA_OUT_W'(fir_resize(wide, DATA_OUT_W, SAT));

endmodule

// File: rtl/axis_fir_pipelined.sv
// Pipelined AXI4-Stream FIR with run-time coefficients, backpressure and packet-aware history.
// Build option FIR_SATURATE_EN selects output saturation instead of two's-complement wrap.
module axis_fir_pipelined
    import fir_pkg::*;
#(
    parameter int  DATA_IN_W     = 16,
    parameter int  COEF_W        = 16,
    parameter int  NUM_TAPS      = 8,
    parameter int  DATA_OUT_W    = 32,
    parameter int  OUT_SHIFT     = 0,
    parameter int  COEF_RESET    = 16,
    parameter bit  CLEAR_ON_LAST = 1'b1,
    localparam int ADDR_W        = fir_clog2(NUM_TAPS)
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset_n,
    input  logic                         s_axis_valid,
    input  logic signed [DATA_IN_W-1:0]  s_axis_data,
    input  logic                         s_axis_last,
    output logic                         s_axis_ready,
    output logic                         m_axis_valid,
    output logic signed [DATA_OUT_W-1:0] m_axis_data,
    output logic                         m_axis_last,
    input  logic                         m_axis_ready,
    input  logic                         coef_we,
    input  logic [ADDR_W-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0]     coef_wdata
);

    localparam int PROD_W = DATA_IN_W + COEF_W;
    localparam int ACC_W  = fir_acc_w(DATA_IN_W, COEF_W, NUM_TAPS);

    if (NUM_TAPS < 2 || NUM_TAPS > MAX_TAPS) begin : g_bad_taps
        $error("axis_fir_pipelined: NUM_TAPS must be within 2..64");
    end

    logic signed [COEF_W-1:0]     coef_q [NUM_TAPS];
    logic signed [COEF_W-1:0]     coef_d [NUM_TAPS];
    logic signed [DATA_IN_W-1:0]  x_q    [NUM_TAPS-1];
    logic signed [DATA_IN_W-1:0]  x_d    [NUM_TAPS-1];
    logic signed [DATA_IN_W-1:0]  tap    [NUM_TAPS];
    logic signed [PROD_W-1:0]     prod_q [NUM_TAPS];
    logic signed [PROD_W-1:0]     prod_d [NUM_TAPS];
    logic                         v1_q, v1_d;
    logic                         l1_q, l1_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_last_q, m_last_d;
    logic signed [DATA_OUT_W-1:0] m_data_q, m_data_d;
    logic signed [DATA_OUT_W-1:0] quant;
    logic signed [ACC_W-1:0]      acc;
    logic                         adv;
    logic                         s_fire;

    // Ready depends only on the output side so upstream never sees a combinational loop.
    assign adv          = !m_valid_q || m_axis_ready;
    assign s_fire       = s_axis_valid && adv;
    assign s_axis_ready = adv;
    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_last  = m_last_q;

    always_comb begin
        tap[0] = s_axis_data;
        for (int k = 1; k < NUM_TAPS; k++) begin
            tap[k] = x_q[k-1];
        end
    end

    always_comb begin
        x_d = x_q;
        if (s_fire) begin
            if (CLEAR_ON_LAST && s_axis_last) begin
                for (int k = 0; k < NUM_TAPS - 1; k++) begin
                    x_d[k] = '0;
                end
            end else begin
                x_d[0] = s_axis_data;
                for (int k = 1; k < NUM_TAPS - 1; k++) begin
                    x_d[k] = x_q[k-1];
                end
            end
        end
    end

    // The multiply stage reads coef_q, so a write landing with s_fire only affects later samples.
    always_comb begin
        coef_d = coef_q;
        if (coef_we && (32'(coef_addr) < NUM_TAPS)) begin
            coef_d[coef_addr] = coef_wdata;
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
    end

    fir_out_quantize #(
        .ACC_W      (ACC_W),
        .DATA_OUT_W (DATA_OUT_W),
        .OUT_SHIFT  (OUT_SHIFT)
    ) u_quant (
        .acc_i  (acc),
        .data_o (quant)
    );

    always_comb begin
        prod_d    = prod_q;
        v1_d      = v1_q;
        l1_d      = l1_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (adv) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(tap[k]);
            end
            v1_d      = s_fire;
            l1_d      = s_axis_last;
            m_valid_d = v1_q;
            m_data_d  = quant;
            m_last_d  = l1_q;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= COEF_W'(COEF_RESET);
                prod_q[k] <= '0;
            end
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                x_q[k] <= '0;
            end
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            coef_q    <= coef_d;
            x_q       <= x_d;
            prod_q    <= prod_d;
            v1_q      <= v1_d;
            l1_q      <= l1_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule

// File: tb/tb_axis_fir_pipelined.sv
// Bench for axis_fir_pipelined: directed vector tables and randomized traffic on two instances
// (default build, and a 16-bit output with shift 2 and no history clear) against a queue model.
module tb_axis_fir_pipelined;

    localparam int TAPS = 8;
`ifdef FIR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint a;
        longint b;
        logic   last;
    } exp_t;

    typedef struct {
        logic signed [15:0] d;
        logic               l;
        longint             exp;
        logic               exp_l;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               s_valid, s_last, m_ready, coef_we;
    logic signed [15:0] s_data, coef_wdata;
    logic [2:0]         coef_addr;
    logic               s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_last_a, m_last_b;
    logic signed [31:0] m_data_a;
    logic signed [15:0] m_data_b;

    axis_fir_pipelined u_dut_a (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready_a),
        .m_axis_valid(m_valid_a), .m_axis_data(m_data_a), .m_axis_last(m_last_a), .m_axis_ready(m_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    axis_fir_pipelined #(.DATA_OUT_W(16), .OUT_SHIFT(2), .CLEAR_ON_LAST(1'b0)) u_dut_b (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready_b),
        .m_axis_valid(m_valid_b), .m_axis_data(m_data_b), .m_axis_last(m_last_b), .m_axis_ready(m_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint cm [TAPS];
    longint hist_a [$];
    longint hist_b [$];
    exp_t   exp_q [$];
    exp_t   obs_q [$];
    exp_t   mon_e;
    vec_t   tbl [$];
    logic   stall_prev = 1'b0;
    longint prev_a, prev_b;
    logic   prev_l;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint quant(input longint acc, input int sh, input int w);
        longint s, hi, lo, m;
        s  = acc >>> sh;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (SAT) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        m = s & ((longint'(1) << w) - 1);
        if (m > hi) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic model_accept(input longint d, input logic last);
        exp_t   e;
        longint acc;
        hist_a.push_front(d);
        if (hist_a.size() > TAPS) void'(hist_a.pop_back());
        hist_b.push_front(d);
        if (hist_b.size() > TAPS) void'(hist_b.pop_back());
        acc = 0;
        foreach (hist_a[k]) acc += cm[k] * hist_a[k];
        e.a = quant(acc, 0, 32);
        acc = 0;
        foreach (hist_b[k]) acc += cm[k] * hist_b[k];
        e.b = quant(acc, 2, 16);
        e.last = last;
        exp_q.push_back(e);
        if (last) hist_a.delete();
    endtask

    task automatic model_reset();
        foreach (cm[k]) cm[k] = 16;
        hist_a.delete();
        hist_b.delete();
        exp_q.delete();
        stall_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if (s_ready_a !== (!m_valid_a || m_ready) || s_ready_b !== s_ready_a || m_valid_b !== m_valid_a) begin
                n_err++;
                $display("FAIL handshake: s_ready=%b/%b m_valid=%b/%b m_ready=%b", s_ready_a, s_ready_b,
                         m_valid_a, m_valid_b, m_ready);
            end
            if (stall_prev) begin
                check("stall_hold_a", m_data_a, prev_a);
                check("stall_hold_b", m_data_b, prev_b);
                check("stall_hold_last", m_last_a, prev_l);
            end
            stall_prev = m_valid_a && !m_ready;
            prev_a = m_data_a;
            prev_b = m_data_b;
            prev_l = m_last_a;
            if (m_valid_a && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_extra: got %0d, expected no output", m_data_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_a", m_data_a, mon_e.a);
                    check("out_b", m_data_b, mon_e.b);
                    check("out_last_a", m_last_a, mon_e.last);
                    check("out_last_b", m_last_b, mon_e.last);
                    mon_e.a = m_data_a;
                    mon_e.b = m_data_b;
                    mon_e.last = m_last_a;
                    obs_q.push_back(mon_e);
                end
            end
            if (s_valid && s_ready_a) model_accept(s_data, s_last);
            if (coef_we) cm[coef_addr] = coef_wdata;
        end
    end

    task automatic send(input logic signed [15:0] d, input logic l);
        int   t;
        logic acc;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            acc = s_ready_a;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic write_coef(input int a, input longint v);
        coef_we    = 1'b1;
        coef_addr  = 3'(a);
        coef_wdata = 16'(v);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    function automatic void add(input int d, input logic l, input longint e, input logic el);
        vec_t v;
        v.d = 16'(d);
        v.l = l;
        v.exp = e;
        v.exp_l = el;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint held;
        s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
        coef_we = 0; coef_addr = 0; coef_wdata = 0;
        model_reset();
        // impulse, then step ending a packet, then a short packet and a fresh one
        add(1, 0, 16, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 16, 0);
        add(0, 0, 0, 0); add(0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(100, 0, 1600 * i, 0);
        add(100, 0, 12800, 0); add(100, 1, 12800, 1);
        add(10, 0, 160, 0); add(10, 1, 320, 1); add(10, 0, 160, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", m_valid_a, 0);
        check("rst_m_data", m_data_a, 0);
        check("rst_m_last", m_last_a, 0);
        check("rst_s_ready_empty", s_ready_a, 1);

        @(posedge clk); #1;
        m_ready = 1; s_valid = 1; s_data = 1; s_last = 0;
        @(negedge clk); check("lat_pre", m_valid_a, 0);
        @(posedge clk); #1; s_valid = 0; s_data = 0;
        @(negedge clk); check("lat_stage1", m_valid_a, 0);
        @(negedge clk); check("lat_valid", m_valid_a, 1); check("lat_data", m_data_a, 16);
        @(posedge clk); #1;
        repeat (7) send(0, 0);
        drain();

        obs_q.delete();
        foreach (tbl[i]) send(tbl[i].d, tbl[i].l);
        drain();
        check("tbl_count", obs_q.size(), tbl.size());
        for (int i = 0; i < tbl.size() && i < obs_q.size(); i++) begin
            check($sformatf("tbl%0d_data", i), obs_q[i].a, tbl[i].exp);
            check($sformatf("tbl%0d_last", i), obs_q[i].last, tbl[i].exp_l);
        end

        obs_q.delete();
        send(3, 0); send(4, 0); send(5, 0);
        m_ready = 0; s_valid = 1; s_data = 6; s_last = 0;
        @(negedge clk);
        held = m_data_a;
        check("bp_valid", m_valid_a, 1);
        repeat (5) begin
            check("bp_s_ready", s_ready_a, 0);
            check("bp_hold", m_data_a, held);
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_ready = 1;
        send(6, 0);
        drain();
        check("bp_count", obs_q.size(), 4);

        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        obs_q.delete();
        coef_we = 1; coef_addr = 0; coef_wdata = -16'sd1;
        send(5, 0);
        coef_we = 0;
        send(-7, 0); send(5, 0);
        drain();
        check("coef_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("coef_same_cycle", obs_q[0].a, 80);
            check("coef_neg_a", obs_q[1].a, 7);
            check("coef_pos_a", obs_q[2].a, -5);
            check("coef_shift_b0", obs_q[0].b, 20);
            check("coef_shift_b2", obs_q[2].b, -2);
        end

        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        obs_q.delete();
        repeat (10) send(32767, 0);
        drain();
        if (obs_q.size() == 10) begin
            check("big_a", obs_q[9].a, SAT ? 64'sd2147483647 : -64'sd524280);
            check("big_b", obs_q[9].b, SAT ? 64'sd32767 : 64'sd2);
        end else begin
            check("big_count", obs_q.size(), 10);
        end

        s_valid = 1; s_data = 9; s_last = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("mid_rst_valid", m_valid_a, 0);
        check("mid_rst_data", m_data_a, 0);
        check("mid_rst_s_ready", s_ready_a, 1);
        model_reset();
        s_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        obs_q.delete();
        send(1, 0);
        drain();
        check("mid_rst_coef_reload", obs_q.size() > 0 ? obs_q[0].a : -1, 16);

        for (int c = 0; c < 800; c++) begin
            s_valid    = ($urandom_range(3) != 0);
            s_data     = 16'($urandom);
            s_last     = ($urandom_range(9) == 0);
            m_ready    = ($urandom_range(9) < 7);
            coef_we    = ($urandom_range(19) == 0);
            coef_addr  = 3'($urandom);
            coef_wdata = 16'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 0; coef_we = 0; m_ready = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
